// File: rtl/iir_coef_ctrl.sv
// Coefficient manager for one IIR core: host-written shadow bank, active bank
// swapped in only after the core has drained, plus the gate on the core input.
module iir_coef_ctrl #(
    parameter int DW     = 24,
    parameter int COEFW  = 18,
    parameter int COEFQ  = 16,
    parameter int ORDER  = 2,
    parameter int MAXINF = 1,
    localparam int N     = (ORDER + 1) * 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(N)-1:0]           wr_addr,
    input  logic signed [COEFW-1:0]        wr_data,
    input  logic                           commit,
    output logic                           commit_busy,
    output logic                           commit_done,
    output logic                           wr_err,
    input  logic signed [DW-1:0]           s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic signed [DW-1:0]           m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    input  logic                           core_tvalid,
    input  logic                           core_tready,
    output logic signed [N-1:0][COEFW-1:0] coefs,
    output logic                           inflight_err
);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(MAXINF + 1);
    localparam logic [COEFW-1:0] UNITY = COEFW'(1) << COEFQ;

    // state | meaning
    // RUN   | gate open, host writes accepted
    // DRAIN | gate closed, waiting for in-flight samples to leave the core
    // SWAP  | gate closed, active bank loads from shadow at end of cycle
    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           inflight;
    logic [N-1:0][COEFW-1:0] shadow;
    logic                    gate, in_hs, out_hs;
    logic                    addr_ok, wr_ok, wr_bad, commit_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (commit) state_nxt = DRAIN;
            DRAIN:   if (inflight == '0) state_nxt = SWAP;
            SWAP:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign gate          = (state == RUN) && (inflight < CW'(MAXINF));
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = s_axis_tvalid && gate;
    assign s_axis_tready = m_axis_tready && gate;
    assign in_hs         = m_axis_tvalid && m_axis_tready;
    assign out_hs        = core_tvalid && core_tready;
    assign commit_busy   = (state != RUN);

    assign addr_ok    = ({1'b0, wr_addr} < (AW + 1)'(N));
    assign wr_ok      = wr_en && (state == RUN) && addr_ok;
    assign wr_bad     = wr_en && ((state != RUN) || !addr_ok);
    assign commit_bad = commit && (state != RUN);

    // Simultaneous in/out handshakes cancel; a lone decrement at zero is an underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight     <= '0;
            inflight_err <= 1'b0;
        end else if (in_hs && !out_hs) begin
            inflight <= inflight + 1'b1;
        end else if (out_hs && !in_hs) begin
            if (inflight == '0) inflight_err <= 1'b1;
            else                inflight     <= inflight - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                shadow[i] <= (i == 0) ? UNITY : '0;
                coefs[i]  <= (i == 0) ? UNITY : '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_ok && (wr_addr == AW'(i))) shadow[i] <= wr_data;
            end
            if (state == SWAP) coefs <= shadow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_done <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            commit_done <= (state == SWAP);
            wr_err      <= wr_bad || commit_bad;
        end
    end
endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Self-checking bench for iir_coef_ctrl: scenario tasks against a bank/queue model.
module tb_iir_coef_ctrl;
    localparam int DW     = 24;
    localparam int COEFW  = 18;
    localparam int COEFQ  = 16;
    localparam int ORDER  = 2;
    localparam int MAXINF = 1;
    localparam int N      = (ORDER + 1) * 2;
    localparam int AW     = $clog2(N);

    typedef logic [N-1:0][COEFW-1:0] bank_t;

    logic clk = 1'b0;
    logic rst;
    logic wr_en, commit;
    logic [AW-1:0] wr_addr;
    logic signed [COEFW-1:0] wr_data;
    logic commit_busy, commit_done, wr_err, inflight_err;
    logic signed [DW-1:0] s_tdata, m_tdata;
    logic s_tvalid, s_tready, m_tvalid, m_tready;
    logic core_tvalid, core_tready;
    logic signed [N-1:0][COEFW-1:0] coefs;

    int n_cmp = 0;
    int n_err = 0;
    logic [COEFW-1:0] shadow_m [N];
    logic [COEFW-1:0] active_m [N];

    always #5 clk = ~clk;

    iir_coef_ctrl #(.DW(DW), .COEFW(COEFW), .COEFQ(COEFQ), .ORDER(ORDER), .MAXINF(MAXINF)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .commit_busy(commit_busy), .commit_done(commit_done), .wr_err(wr_err),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .core_tvalid(core_tvalid), .core_tready(core_tready),
        .coefs(coefs), .inflight_err(inflight_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bank_t bank(input logic [COEFW-1:0] b [N]);
        bank_t p;
        for (int i = 0; i < N; i++) p[i] = b[i];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            shadow_m[i] = (i == 0) ? COEFW'(1 << COEFQ) : '0;
            active_m[i] = shadow_m[i];
        end
    endtask

    task automatic idle_inputs();
        wr_en = 0; commit = 0; wr_addr = '0; wr_data = '0;
        s_tvalid = 0; s_tdata = '0; m_tready = 0; core_tvalid = 0; core_tready = 0;
    endtask

    task automatic wr(input int addr, input logic [COEFW-1:0] data);
        wr_en = 1; wr_addr = AW'(addr); wr_data = data;
        step();
        wr_en = 0;
        if (addr < N) shadow_m[addr] = data;
        n_cmp++;
        if (wr_err !== (addr >= N))
            $display("FAIL wr_err addr=%0d: got %b want %b", addr, wr_err, (addr >= N));
        if (wr_err !== (addr >= N)) n_err++;
    endtask

    task automatic send_sample(input logic signed [DW-1:0] d);
        s_tdata = d; s_tvalid = 1; m_tready = 1;
        #1;
        n_cmp++;
        if (m_tdata !== d || m_tvalid !== 1'b1 || s_tready !== 1'b1) begin
            $display("FAIL passthru: got data=%0d v=%b r=%b want data=%0d v=1 r=1", m_tdata, m_tvalid, s_tready, d);
            n_err++;
        end
        step();
        s_tvalid = 0;
        #1;
        n_cmp++;
        if (s_tready !== 1'b0) begin
            $display("FAIL inflight_limit: got s_tready=%b want 0", s_tready);
            n_err++;
        end
        core_tvalid = 1; core_tready = 1;
        step();
        core_tvalid = 0; core_tready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        model_reset();
        step(); step();
        rst = 0;
        #1;
        n_cmp++;
        if (coefs !== bank(active_m)) begin
            $display("FAIL reset_coefs: got %h want %h", coefs, bank(active_m));
            n_err++;
        end
        n_cmp++;
        if ({commit_busy, commit_done, wr_err, inflight_err} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b want 0000", {commit_busy, commit_done, wr_err, inflight_err});
            n_err++;
        end
        send_sample(DW'(100));
        send_sample(-DW'(5));
    endtask

    task automatic test_random_traffic();
        logic signed [DW-1:0] core_q [$];
        logic open, exp_v, exp_r;
        for (int c = 0; c < 300; c++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata = DW'($urandom);
            core_tvalid = (core_q.size() > 0) && ($urandom_range(0, 1) == 1);
            core_tready = 1'($urandom_range(0, 1));
            #1;
            open = (core_q.size() < MAXINF);
            exp_v = s_tvalid && open;
            exp_r = m_tready && open;
            n_cmp++;
            if (m_tvalid !== exp_v || s_tready !== exp_r || m_tdata !== s_tdata) begin
                $display("FAIL rand_gate c=%0d: got v=%b r=%b d=%0h want v=%b r=%b d=%0h",
                         c, m_tvalid, s_tready, m_tdata, exp_v, exp_r, s_tdata);
                n_err++;
            end
            if (core_tvalid && core_tready) void'(core_q.pop_front());
            if (exp_v && m_tready) core_q.push_back(s_tdata);
            step();
        end
        s_tvalid = 0;
        while (core_q.size() > 0) begin
            core_tvalid = 1; core_tready = 1;
            step();
            void'(core_q.pop_front());
        end
        core_tvalid = 0; core_tready = 0;
        n_cmp++;
        if (inflight_err !== 1'b0 || coefs !== bank(active_m)) begin
            $display("FAIL rand_end: got err=%b coefs=%h want err=0 coefs=%h", inflight_err, coefs, bank(active_m));
            n_err++;
        end
    endtask

    task automatic test_idle_commit();
        wr(0, COEFW'(32768));
        wr(4, COEFW'(1000));
        wr(1, COEFW'($urandom));
        wr(3, COEFW'($urandom));
        commit = 1; m_tready = 1;
        #1;
        n_cmp++;
        if (commit_busy !== 1'b0 || coefs !== bank(active_m)) begin
            $display("FAIL commit_t: got busy=%b coefs=%h want busy=0 coefs=%h", commit_busy, coefs, bank(active_m));
            n_err++;
        end
        step();
        commit = 0;
        n_cmp++;
        if (commit_busy !== 1'b1 || commit_done !== 1'b0 || coefs !== bank(active_m)) begin
            $display("FAIL commit_t1: got busy=%b done=%b coefs=%h want 1 0 %h", commit_busy, commit_done, coefs, bank(active_m));
            n_err++;
        end
        step();
        s_tvalid = 1;
        #1;
        n_cmp++;
        if (commit_busy !== 1'b1 || commit_done !== 1'b0 || coefs !== bank(active_m) ||
            s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
            $display("FAIL commit_t2: got busy=%b done=%b r=%b v=%b want 1 0 0 0", commit_busy, commit_done, s_tready, m_tvalid);
            n_err++;
        end
        step();
        s_tvalid = 0;
        active_m = shadow_m;
        n_cmp++;
        if (commit_busy !== 1'b0 || commit_done !== 1'b1 || coefs !== bank(active_m) || s_tready !== 1'b1) begin
            $display("FAIL commit_t3: got busy=%b done=%b r=%b coefs=%h want 0 1 1 %h", commit_busy, commit_done, s_tready, coefs, bank(active_m));
            n_err++;
        end
        step();
        m_tready = 0;
        n_cmp++;
        if (commit_done !== 1'b0) begin
            $display("FAIL commit_done_pulse: got %b want 0", commit_done);
            n_err++;
        end
    endtask

    task automatic test_drain();
        int bad;
        wr(2, COEFW'($urandom));
        wr(5, COEFW'($urandom));
        s_tvalid = 1; m_tready = 1; s_tdata = DW'($urandom);
        step();
        s_tvalid = 0;
        commit = 1;
        step();
        commit = 0;
        core_tvalid = 1; core_tready = 0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (s_tready !== 1'b0 || commit_busy !== 1'b1 || commit_done !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            $display("FAIL drain_stall: got %0d bad cycles want 0", bad);
            n_err++;
        end
        core_tready = 1;
        step();
        core_tvalid = 0; core_tready = 0;
        // count is seen as zero this cycle; SWAP follows
        n_cmp++;
        if (commit_busy !== 1'b1 || commit_done !== 1'b0 || coefs !== bank(active_m)) begin
            $display("FAIL drain_h1: got busy=%b done=%b want 1 0", commit_busy, commit_done);
            n_err++;
        end
        step();
        n_cmp++;
        if (commit_busy !== 1'b1 || commit_done !== 1'b0 || coefs !== bank(active_m)) begin
            $display("FAIL drain_swap: got busy=%b done=%b want 1 0", commit_busy, commit_done);
            n_err++;
        end
        step();
        active_m = shadow_m;
        n_cmp++;
        if (commit_busy !== 1'b0 || commit_done !== 1'b1 || coefs !== bank(active_m)) begin
            $display("FAIL drain_done: got busy=%b done=%b coefs=%h want 0 1 %h", commit_busy, commit_done, coefs, bank(active_m));
            n_err++;
        end
        m_tready = 0;
    endtask

    task automatic test_rejected();
        int dones;
        wr(N, COEFW'($urandom));
        wr(7, COEFW'($urandom));
        wr(2, COEFW'($urandom));
        s_tvalid = 1; m_tready = 1; s_tdata = DW'($urandom);
        step();
        s_tvalid = 0;
        commit = 1;
        step();
        commit = 0;
        core_tvalid = 1; core_tready = 0;
        wr_en = 1; wr_addr = 3; wr_data = COEFW'($urandom);
        step();
        wr_en = 0;
        n_cmp++;
        if (wr_err !== 1'b1) begin
            $display("FAIL wr_in_drain: got wr_err=%b want 1", wr_err);
            n_err++;
        end
        step();
        n_cmp++;
        if (wr_err !== 1'b0) begin
            $display("FAIL wr_err_pulse: got %b want 0", wr_err);
            n_err++;
        end
        commit = 1;
        step();
        commit = 0;
        n_cmp++;
        if (wr_err !== 1'b1) begin
            $display("FAIL commit_in_drain: got wr_err=%b want 1", wr_err);
            n_err++;
        end
        core_tready = 1;
        step();
        core_tvalid = 0; core_tready = 0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (commit_done === 1'b1) dones++;
            step();
        end
        active_m = shadow_m;
        n_cmp++;
        if (dones != 1) begin
            $display("FAIL single_done: got %0d done pulses want 1", dones);
            n_err++;
        end
        n_cmp++;
        if (coefs !== bank(active_m)) begin
            $display("FAIL rejected_bank: got %h want %h", coefs, bank(active_m));
            n_err++;
        end
        m_tready = 0;
    endtask

    task automatic test_same_cycle();
        int waited;
        wr_en = 1; wr_addr = 1; wr_data = 7; commit = 1;
        step();
        wr_en = 0; commit = 0;
        shadow_m[1] = 7;
        n_cmp++;
        if (wr_err !== 1'b0) begin
            $display("FAIL same_cycle_err: got %b want 0", wr_err);
            n_err++;
        end
        waited = 0;
        while (commit_done !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        active_m = shadow_m;
        n_cmp++;
        if (commit_done !== 1'b1) begin
            $display("FAIL same_cycle_timeout: got done=%b want 1", commit_done);
            n_err++;
        end
        n_cmp++;
        if (coefs !== bank(active_m) || $signed(coefs[1]) != 7) begin
            $display("FAIL same_cycle_coef1: got %0d want 7", $signed(coefs[1]));
            n_err++;
        end
        step();
    endtask

    task automatic test_underflow_and_reset();
        core_tvalid = 1; core_tready = 1;
        step();
        core_tvalid = 0; core_tready = 0;
        n_cmp++;
        if (inflight_err !== 1'b1) begin
            $display("FAIL underflow_set: got %b want 1", inflight_err);
            n_err++;
        end
        for (int i = 0; i < 5; i++) send_sample(DW'($urandom));
        n_cmp++;
        if (inflight_err !== 1'b1) begin
            $display("FAIL underflow_sticky: got %b want 1", inflight_err);
            n_err++;
        end
        wr(0, COEFW'($urandom));
        s_tvalid = 1; m_tready = 1; s_tdata = DW'($urandom);
        step();
        s_tvalid = 0;
        commit = 1;
        step();
        commit = 0;
        rst = 1;
        model_reset();
        #1;
        n_cmp++;
        if (commit_busy !== 1'b0 || inflight_err !== 1'b0 || coefs !== bank(active_m)) begin
            $display("FAIL reset_mid_commit: got busy=%b err=%b coefs=%h want 0 0 %h", commit_busy, inflight_err, coefs, bank(active_m));
            n_err++;
        end
        step();
        rst = 0;
        core_tvalid = 1; core_tready = 1;
        step();
        core_tvalid = 0; core_tready = 0;
        n_cmp++;
        if (inflight_err !== 1'b1 || commit_done !== 1'b0 || coefs !== bank(active_m)) begin
            $display("FAIL post_reset_underflow: got err=%b done=%b want 1 0", inflight_err, commit_done);
            n_err++;
        end
        rst = 1;
        step();
        rst = 0;
        n_cmp++;
        if (inflight_err !== 1'b0) begin
            $display("FAIL err_cleared: got %b want 0", inflight_err);
            n_err++;
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_random_traffic();
        test_idle_commit();
        test_drain();
        test_rejected();
        test_same_cycle();
        test_underflow_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/iir_coef_ctrl.md
# iir_coef_ctrl

Coefficient manager and input gate for a single IIR filter core. Holds a host-writable shadow coefficient bank and an active bank that drives the core's `coefs` input. New coefficients are committed only when the core is idle, so no sample is ever computed with a mix of old and new coefficients. The block sits between the upstream sample stream and the core's input, and observes the core's output handshake.

## Interface

**Parameters**
- `DW`, default 24: sample width.
- `COEFW`, default 18: coefficient width, signed.
- `COEFQ`, default 16: coefficient fractional bits.
- `ORDER`, default 2: filter order. Localparam `N = (ORDER+1)*2`.
- `MAXINF`, default 1: maximum number of samples in flight inside the core.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `wr_en`, in, 1: shadow-bank write strobe.
- `wr_addr`, in, `$clog2(N)`: shadow coefficient index.
- `wr_data`, in, `COEFW`, signed: coefficient value.
- `commit`, in, 1: single-cycle request to copy the shadow bank into the active bank.
- `commit_busy`, out, 1: high while a commit is pending or executing.
- `commit_done`, out, 1: one-cycle pulse when the new active bank becomes visible.
- `wr_err`, out, 1: one-cycle pulse when a write or commit is rejected.
- `s_axis_tdata`, in, `DW`, signed: upstream samples.
- `s_axis_tvalid`, in, 1: upstream valid.
- `s_axis_tready`, out, 1: upstream ready.
- `m_axis_tdata`, out, `DW`, signed: samples to the core.
- `m_axis_tvalid`, out, 1: valid to the core.
- `m_axis_tready`, in, 1: core input ready.
- `core_tvalid`, in, 1: core output valid (monitor only).
- `core_tready`, in, 1: core output ready (monitor only).
- `coefs`, out, `COEFW` x `N`, signed: active bank, registered.
- `inflight_err`, out, 1: sticky flag, set on counter underflow; cleared only by reset.

## Operation

**Reset values**
- Active and shadow banks: `coefs[0] = 1<<COEFQ` (unity pass-through), all other entries 0.
- State is RUN. The in-flight count is 0.
- `commit_busy`, `commit_done`, `wr_err` and `inflight_err` are all 0.

**States**
- **RUN**
  - Samples pass through. `m_axis_tdata = s_axis_tdata`.
  - `m_axis_tvalid = s_axis_tvalid && gate`.
  - `s_axis_tready = m_axis_tready && gate`.
  - `gate = (state==RUN) && (inflight < MAXINF)`.
- **DRAIN**
  - The gate is closed (`m_axis_tvalid = 0`, `s_axis_tready = 0`).
  - Waits until the registered in-flight count equals 0.
- **SWAP**
  - Lasts one cycle. The gate stays closed.
  - The active bank is loaded from the shadow bank at the end of this cycle.

**Transitions**
- RUN -> DRAIN when `commit` is asserted.
- DRAIN -> SWAP when `inflight == 0`.
- SWAP -> RUN unconditionally.

**Status outputs**
- `commit_busy = (state != RUN)`, decoded from the state register.
- `commit_done` is registered and goes high in the cycle after SWAP, which is the first cycle the new `coefs` are visible.

**In-flight counter**
- Increments on an input handshake (`m_axis_tvalid && m_axis_tready`).
- Decrements on an output handshake (`core_tvalid && core_tready`).
- Both handshakes in the same cycle leave the count unchanged.
- A decrement at 0 holds the count at 0 and sets `inflight_err`.
- Counter width is `$clog2(MAXINF+1)`.

**Writes**
- While in RUN, `wr_en` writes `wr_data` into `shadow[wr_addr]`.
- An out-of-range `wr_addr` (>= N) is dropped and pulses `wr_err`.
- `wr_en` while `commit_busy` is dropped and pulses `wr_err`. The shadow bank is unchanged.
- `wr_en` and `commit` in the same RUN cycle: the write lands first and is included in that commit.
- `commit` while `commit_busy` is ignored and pulses `wr_err`.

**Coefficient values**
- Values are stored raw. There is no sign manipulation; the core negates the feedback terms itself.

## Timing

- The gate adds zero latency: the data and valid path is combinational in RUN.
- **Commit with an idle core**, `commit` at cycle t:
  - t+1: DRAIN.
  - t+2: SWAP.
  - t+3: new `coefs` and `commit_done` = 1; state is RUN and the gate reopens.
- **Commit in the same cycle as an input handshake**: the sample is accepted with the old coefficients. DRAIN then waits for its output handshake.
- **Reset mid-commit**:
  - Immediately returns to RUN with the pass-through banks. Any pending commit is lost.
  - The in-flight count returns to 0. Samples already in the core are untracked, and a later decrement at 0 is an underflow; the reset source must also reset the core.
- The `coefs` outputs change only on the SWAP -> RUN edge or on reset.

## Test plan

1. **Reset pass-through**: assert `rst`, then stream samples 100, -5. Required: `coefs = {65536, 0, 0, 0, 0, 0}`, samples forwarded unchanged, all flags 0.
2. **Idle commit**:
   - Write `shadow[0] = 32768` and `shadow[4] = 1000`, then pulse `commit` at cycle t with the core idle.
   - Required: `commit_busy` high for t+1..t+2, `commit_done` and the new `coefs` at t+3.
   - Required: `coefs` unchanged before t+3.
3. **Drain hold-off**:
   - Accept a sample, then pulse `commit` with the core output stalled for 10 cycles.
   - Required: `s_axis_tready = 0` throughout the stall, SWAP one cycle after the output handshake, `commit_done` one cycle after that.
4. **Rejected accesses**:
   - `wr_en` during DRAIN, and `wr_addr = N`: required `wr_err` pulses and the shadow bank is unchanged.
   - `commit` during DRAIN: required `wr_err` pulse and only one `commit_done`.
5. **Same-cycle write and commit**: `wr_en` to address 1 with value 7 together with `commit` in RUN. Required: after `commit_done`, `coefs[1] = 7`.
6. **In-flight limit and underflow**:
   - With `MAXINF = 1` and the core output stalled: required `s_axis_tready = 0` after one accepted sample.
   - Spurious `core_tvalid && core_tready` at count 0: required `inflight_err` set and held until `rst`.
